// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback buffer.
// Register-file encodings match the operand-stage rf_signal.
package alu_wb_pkg;

    localparam logic RF_INT = 1'b0;
    localparam logic RF_FP  = 1'b1;

    localparam int XLEN_DEF = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] data;
        logic [4:0]          rd;
        logic                rf;
    } entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Result handshake from the ALU into the writeback buffer.
// Master is the ALU side, slave is the buffer.
interface alu_writeback_if #(
    parameter int XLEN = 32
);
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_rd;
    logic            res_rf;

    modport master (
        output res_valid, res_data, res_rd, res_rf,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_rd, res_rf,
        output res_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO with synchronous flush; exposes storage and
// valid bits so the owner can search buffered entries.
module wb_fifo
    import alu_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 38,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] mem [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PW-1:0]    rd_ptr,
    output logic [CW-1:0]    count
);

    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr]   <= din;
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Buffers ALU results and drains them in order to the integer
// or FP register-file write port; forwards buffered values.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_width(DEPTH),
    localparam int W     = XLEN + 6
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_writeback_if.slave  res,
    input  logic            flush,
    input  logic            int_wr_ready,
    output logic            int_we,
    output logic [4:0]      int_waddr,
    output logic [XLEN-1:0] int_wdata,
    input  logic            fp_wr_ready,
    output logic            fp_we,
    output logic [4:0]      fp_waddr,
    output logic [XLEN-1:0] fp_wdata,
    input  logic [4:0]      lookup_rd,
    input  logic            lookup_rf,
    output logic            fwd_valid,
    output logic [XLEN-1:0] fwd_data,
    output logic [CW-1:0]   count
);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            rf;
    } ent_t;

    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr;
    ent_t             head;
    logic             x0;
    logic             push;
    logic             pop;
    logic             has;

    assign res.res_ready = (count != CW'(DEPTH));

    // Integer x0 writes complete the handshake but are never stored.
    assign x0   = (res.res_rf == RF_INT) && (res.res_rd == 5'd0);
    assign push = res.res_valid && res.res_ready && !x0;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    ({res.res_data, res.res_rd, res.res_rf}),
        .mem    (mem),
        .valid  (valid),
        .rd_ptr (rd_ptr),
        .count  (count)
    );

    assign head = ent_t'(mem[rd_ptr]);
    assign has  = (count != '0);

    assign int_we = has && !flush && (head.rf == RF_INT) && int_wr_ready;
    assign fp_we  = has && !flush && (head.rf == RF_FP) && fp_wr_ready;
    assign pop    = int_we || fp_we;

    assign int_waddr = head.rd;
    assign int_wdata = head.data;
    assign fp_waddr  = head.rd;
    assign fp_wdata  = head.data;

    // Walk oldest to youngest so the last hit is the youngest match.
    logic [PW-1:0] idx;
    ent_t          e;

    always_comb begin
        fwd_valid = 1'b0;
        fwd_data  = '0;
        idx       = '0;
        e         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            e   = ent_t'(mem[idx]);
            if (valid[idx] && e.rd == lookup_rd && e.rf == lookup_rf) begin
                fwd_valid = 1'b1;
                fwd_data  = e.data;
            end
        end
        if (flush || (lookup_rf == RF_INT && lookup_rd == 5'd0)) begin
            fwd_valid = 1'b0;
            fwd_data  = '0;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed plus random stimulus for alu_writeback against a
// queue-based reference model of the writeback buffer.
module tb_alu_writeback;
    import alu_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        int_wr_ready;
    logic        int_we;
    logic [4:0]  int_waddr;
    logic [31:0] int_wdata;
    logic        fp_wr_ready;
    logic        fp_we;
    logic [4:0]  fp_waddr;
    logic [31:0] fp_wdata;
    logic [4:0]  lookup_rd;
    logic        lookup_rf;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    entry_t q[$];
    logic   e_ready;
    logic   e_int;
    logic   e_fp;

    alu_writeback_if #(.XLEN(32)) rif ();

    alu_writeback #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res          (rif),
        .flush        (flush),
        .int_wr_ready (int_wr_ready),
        .int_we       (int_we),
        .int_waddr    (int_waddr),
        .int_wdata    (int_wdata),
        .fp_wr_ready  (fp_wr_ready),
        .fp_we        (fp_we),
        .fp_waddr     (fp_waddr),
        .fp_wdata     (fp_wdata),
        .lookup_rd    (lookup_rd),
        .lookup_rf    (lookup_rf),
        .fwd_valid    (fwd_valid),
        .fwd_data     (fwd_data),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] rd,
                         input logic rf);
        rif.res_valid = 1'b1;
        rif.res_data  = d;
        rif.res_rd    = rd;
        rif.res_rf    = rf;
    endtask

    task automatic idle();
        rif.res_valid = 1'b0;
    endtask

    // Compare every output against the model; called mid-cycle.
    task automatic settle_check();
        logic        fv;
        logic [31:0] fd;
        #2;
        e_ready = (q.size() != DEPTH);
        e_int = 1'b0;
        e_fp  = 1'b0;
        if (q.size() != 0 && !flush) begin
            e_int = (q[0].rf == 1'b0) && int_wr_ready;
            e_fp  = (q[0].rf == 1'b1) && fp_wr_ready;
        end
        fv = 1'b0;
        fd = '0;
        if (!flush && !(lookup_rf == 1'b0 && lookup_rd == 5'd0)) begin
            foreach (q[i]) begin
                if (q[i].rd == lookup_rd && q[i].rf == lookup_rf) begin
                    fv = 1'b1;
                    fd = q[i].data;
                end
            end
        end
        chk("res_ready", 64'(rif.res_ready), 64'(e_ready));
        chk("int_we", 64'(int_we), 64'(e_int));
        chk("fp_we", 64'(fp_we), 64'(e_fp));
        chk("count", 64'(count), 64'(q.size()));
        chk("fwd_valid", 64'(fwd_valid), 64'(fv));
        if (fv) chk("fwd_data", 64'(fwd_data), 64'(fd));
        if (q.size() != 0) begin
            chk("int_waddr", 64'(int_waddr), 64'(q[0].rd));
            chk("int_wdata", 64'(int_wdata), 64'(q[0].data));
            chk("fp_waddr", 64'(fp_waddr), 64'(q[0].rd));
            chk("fp_wdata", 64'(fp_wdata), 64'(q[0].data));
        end
    endtask

    task automatic tick();
        entry_t n;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (e_int || e_fp) void'(q.pop_front());
            if (rif.res_valid && e_ready &&
                !(rif.res_rf == 1'b0 && rif.res_rd == 5'd0)) begin
                n.data = rif.res_data;
                n.rd   = rif.res_rd;
                n.rf   = rif.res_rf;
                q.push_back(n);
            end
        end
        #1;
    endtask

    task automatic cyc();
        settle_check();
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        int_wr_ready = 1'b0;
        fp_wr_ready  = 1'b0;
        lookup_rd    = 5'd0;
        lookup_rf    = 1'b0;
        rif.res_valid = 1'b0;
        rif.res_data  = '0;
        rif.res_rd    = '0;
        rif.res_rf    = 1'b0;
        #12;
        chk("rst_ready", 64'(rif.res_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_int_we", 64'(int_we), 64'd0);
        chk("rst_fp_we", 64'(fp_we), 64'd0);
        chk("rst_waddr", 64'(int_waddr), 64'd0);
        chk("rst_wdata", 64'(int_wdata), 64'd0);
        chk("rst_fwd", 64'(fwd_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single integer result, drained the next cycle
        int_wr_ready = 1'b1;
        fp_wr_ready  = 1'b1;
        drive(32'h12345678, 5'd5, 1'b0);
        cyc();
        idle();
        settle_check();
        chk("t1_int_we", 64'(int_we), 64'd1);
        chk("t1_waddr", 64'(int_waddr), 64'd5);
        chk("t1_wdata", 64'(int_wdata), 64'h12345678);
        chk("t1_fp_we", 64'(fp_we), 64'd0);
        tick();
        settle_check();
        chk("t1_count", 64'(count), 64'd0);
        tick();

        // Integer x0 dropped, f0 kept
        drive(32'hFFFFFFFF, 5'd0, 1'b0);
        settle_check();
        chk("x0_ready", 64'(rif.res_ready), 64'd1);
        tick();
        idle();
        settle_check();
        chk("x0_count", 64'(count), 64'd0);
        chk("x0_int_we", 64'(int_we), 64'd0);
        tick();
        drive(32'h0000CAFE, 5'd0, 1'b1);
        cyc();
        idle();
        settle_check();
        chk("f0_fp_we", 64'(fp_we), 64'd1);
        chk("f0_waddr", 64'(fp_waddr), 64'd0);
        tick();

        // Fill to full, reject a fifth, then drain with pointer wrap
        int_wr_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(32'h100 + 32'(i), 5'(i), 1'b0);
            cyc();
        end
        drive(32'hDEAD, 5'd9, 1'b0);
        settle_check();
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(rif.res_ready), 64'd0);
        tick();
        idle();
        int_wr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle_check();
            chk("drain_addr", 64'(int_waddr), 64'(i));
            tick();
        end
        settle_check();
        chk("drain_empty", 64'(count), 64'd0);
        tick();

        // Blocked integer head holds back an FP entry
        int_wr_ready = 1'b0;
        fp_wr_ready  = 1'b1;
        drive(32'hAAAA, 5'd9, 1'b0);
        cyc();
        drive(32'hBBBB, 5'd10, 1'b1);
        cyc();
        idle();
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("hol_fp_we", 64'(fp_we), 64'd0);
            tick();
        end
        int_wr_ready = 1'b1;
        cyc();
        settle_check();
        chk("hol_fp_go", 64'(fp_we), 64'd1);
        chk("hol_fp_addr", 64'(fp_waddr), 64'd10);
        tick();

        // Youngest-match forwarding
        int_wr_ready = 1'b0;
        fp_wr_ready  = 1'b0;
        drive(32'hA, 5'd7, 1'b1);
        cyc();
        drive(32'hB, 5'd7, 1'b1);
        cyc();
        drive(32'hC, 5'd3, 1'b0);
        lookup_rd = 5'd7;
        lookup_rf = 1'b1;
        settle_check();
        chk("fwd_hit", 64'(fwd_valid), 64'd1);
        chk("fwd_young", 64'(fwd_data), 64'hB);
        tick();
        idle();
        lookup_rf = 1'b0;
        settle_check();
        chk("fwd_rf_miss", 64'(fwd_valid), 64'd0);

        // Flush with a concurrent result
        int_wr_ready = 1'b1;
        fp_wr_ready  = 1'b1;
        lookup_rf    = 1'b1;
        drive(32'hD, 5'd4, 1'b0);
        flush = 1'b1;
        settle_check();
        chk("fl_int_we", 64'(int_we), 64'd0);
        chk("fl_fp_we", 64'(fp_we), 64'd0);
        chk("fl_fwd", 64'(fwd_valid), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        settle_check();
        chk("fl_count", 64'(count), 64'd0);
        tick();

        // Asynchronous reset during drain
        int_wr_ready = 1'b0;
        drive(32'h55, 5'd11, 1'b0);
        cyc();
        drive(32'h66, 5'd12, 1'b0);
        cyc();
        idle();
        int_wr_ready = 1'b1;
        settle_check();
        chk("ar_we_pre", 64'(int_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_we", 64'(int_we), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_waddr", 64'(int_waddr), 64'd0);
        q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) != 0)
                drive($urandom, 5'($urandom_range(0, 7)), 1'($urandom));
            else
                idle();
            int_wr_ready = ($urandom_range(0, 3) != 0);
            fp_wr_ready  = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 24) == 0);
            lookup_rd    = 5'($urandom_range(0, 7));
            lookup_rf    = 1'($urandom);
            cyc();
        end
        idle();
        flush = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
